// File: rtl/sysctl_wb.sv
// sysctl_wb: Wishbone system-control slave.
// Provides a keyed, delayed warm-boot request with abort, two scratch registers
// and a free-running uptime counter.
// Optional watchdog is built when SYSCTL_WATCHDOG_EN is defined. When it expires,
// it forces a boot into image 0.
module sysctl_wb #(
  parameter int DW    = 32,
  parameter int DLY_W = 16,
  parameter int UPT_W = 32,
  parameter int WDT_W = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    wb_addr,
  output logic [DW-1:0] wb_rdata,
  input  logic [DW-1:0] wb_wdata,
  input  logic          wb_we,
  input  logic          wb_cyc,
  output logic          wb_ack,
  output logic          boot_now,
  output logic [1:0]    boot_sel
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_BOOT  = 2'd2;

  localparam logic [7:0] KEY_BOOT  = 8'h5A;
  localparam logic [7:0] KEY_ABORT = 8'hA5;

  // Bus registers
  logic          ack_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rd_val;

  // Control state
  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             boot_now_q;

  // Plain registers
  logic [DLY_W-1:0] dly_q;
  logic [DW-1:0]    scr0_q, scr1_q;
  logic [UPT_W-1:0] upt_q;

  // One transfer is accepted per ack; every write/read happens on the acking edge.
  logic bus_go;
  logic wr_en;
  logic wr_ctrl;
  logic start_req;
  logic abort_req;
  logic wdt_fire;

  assign bus_go    = wb_cyc & ~ack_q;
  assign wr_en     = bus_go & wb_we;
  assign wr_ctrl   = wr_en && (wb_addr == 3'd0);
  assign start_req = wr_ctrl && (wb_wdata[15:8] == KEY_BOOT) && !wb_wdata[2];
  assign abort_req = wr_ctrl && (wb_wdata[15:8] == KEY_ABORT) && wb_wdata[2];

  assign wb_ack   = ack_q;
  assign wb_rdata = rdata_q;
  assign boot_now = boot_now_q;
  assign boot_sel = boot_now_q ? sel_q : 2'b00;

`ifdef SYSCTL_WATCHDOG_EN
  logic             wdt_en_q;
  logic             wdt_fired_q;
  logic [WDT_W-1:0] wdt_reload_q;
  logic [WDT_W-1:0] wdt_cnt_q;
  logic             wr_wdt;
  logic [WDT_W-1:0] wdt_wval;

  assign wr_wdt   = wr_en && (wb_addr == 3'd5);
  assign wdt_wval = wb_wdata[WDT_W-1:0];
  assign wdt_fire = wdt_en_q && (state_q != ST_BOOT) && (wdt_cnt_q == '0);

  // Watchdog: load/feed/disable by write, count down outside BOOT, fire at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_en_q     <= 1'b0;
      wdt_fired_q  <= 1'b0;
      wdt_reload_q <= '0;
      wdt_cnt_q    <= '0;
    end else if (wdt_fire) begin
      wdt_fired_q <= 1'b1;
    end else if (wr_wdt) begin
      if (wdt_wval != '0) begin
        wdt_en_q     <= 1'b1;
        wdt_reload_q <= wdt_wval;
        // Writing the current reload value is a feed; any other value is a new load.
        wdt_cnt_q    <= (wdt_wval == wdt_reload_q) ? wdt_reload_q : wdt_wval;
      end else begin
        wdt_en_q <= 1'b0;
      end
    end else if (wdt_en_q && (state_q != ST_BOOT)) begin
      wdt_cnt_q <= wdt_cnt_q - 1'b1;
    end
  end
`else
  assign wdt_fire = 1'b0;
`endif

  // Boot FSM next-state; the watchdog overrides everything else, including an abort
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          sel_d   = wb_wdata[1:0];
          cnt_d   = dly_q;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (abort_req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_BOOT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BOOT: begin
        state_d = ST_BOOT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (wdt_fire) begin
      state_d = ST_BOOT;
      sel_d   = 2'b00;
    end
  end

  // Boot FSM registers; boot_now is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= 2'b00;
      cnt_q      <= '0;
      boot_now_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      boot_now_q <= boot_now_q | (state_d == ST_BOOT);
    end
  end

  // Read mux: values as seen before the acking edge
  always_comb begin
    rd_val = '0;
    case (wb_addr)
      3'd0: begin
        rd_val[1:0] = sel_q;
        rd_val[5:4] = state_q;
`ifdef SYSCTL_WATCHDOG_EN
        rd_val[6]   = wdt_fired_q;
`endif
      end
      3'd1: rd_val[DLY_W-1:0] = dly_q;
      3'd2: rd_val = scr0_q;
      3'd3: rd_val = scr1_q;
      3'd4: rd_val[UPT_W-1:0] = upt_q;
`ifdef SYSCTL_WATCHDOG_EN
      3'd5: rd_val[WDT_W-1:0] = wdt_cnt_q;
`endif
      default: rd_val = '0;
    endcase
  end

  // Single-cycle ack; read data is forced to zero outside the ack cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= bus_go;
      rdata_q <= bus_go ? rd_val : '0;
    end
  end

  // Writable registers: delay, scratch pair, and uptime (a write clears it over the increment)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q  <= '0;
      scr0_q <= '0;
      scr1_q <= '0;
      upt_q  <= '0;
    end else begin
      if (wr_en && (wb_addr == 3'd1)) dly_q  <= wb_wdata[DLY_W-1:0];
      if (wr_en && (wb_addr == 3'd2)) scr0_q <= wb_wdata;
      if (wr_en && (wb_addr == 3'd3)) scr1_q <= wb_wdata;
      if (wr_en && (wb_addr == 3'd4)) upt_q  <= '0;
      else                            upt_q  <= upt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sysctl_wb.sv
// tb_sysctl_wb: directed self-checking bench for sysctl_wb.
// Watchdog expectations follow SYSCTL_WATCHDOG_EN.
module tb_sysctl_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  wb_addr = '0;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_ack;
  logic        boot_now;
  logic [1:0]  boot_sel;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;     // posedges since the last reset release
  int last_edge;      // edge number of the most recent ack
  logic [31:0] rd, rd2;
  int e;
  int hits;

  sysctl_wb dut (
    .clk      (clk),
    .rst      (rst),
    .wb_addr  (wb_addr),
    .wb_rdata (wb_rdata),
    .wb_wdata (wb_wdata),
    .wb_we    (wb_we),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack),
    .boot_now (boot_now),
    .boot_sel (boot_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transfer: cyc high for one cycle, sampled at the negedge after the ack edge
  task automatic wb_xfer(input logic [2:0] a, input logic we, input logic [31:0] d,
                         output logic [31:0] r);
    @(negedge clk);
    wb_addr  = a;
    wb_we    = we;
    wb_wdata = d;
    wb_cyc   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r         = wb_rdata;
    last_edge = edge_n;
    check_val("ack", {31'd0, wb_ack}, 32'd1);
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    $display("xfer %s addr=%0d wdata=0x%08h rdata=0x%08h edge=%0d",
             we ? "WR" : "RD", a, d, r, last_edge);
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(a, 1'b1, d, dummy);
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [31:0] r);
    wb_xfer(a, 1'b0, 32'd0, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns the edge after which boot_now was first seen high, or -1 on timeout
  task automatic wait_boot(input int max_cyc, output int at_edge);
    at_edge = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (boot_now) begin
        at_edge = edge_n;
        break;
      end
    end
  endtask

  task automatic count_boot(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (boot_now) cnt++;
    end
  endtask

  initial begin
    int a, c, w, f;

    // ---- 1: reset state, bus timing, uptime ----
    do_reset();
    check_val("rst_ack", {31'd0, wb_ack}, 32'd0);
    check_val("rst_rdata", wb_rdata, 32'd0);
    check_val("rst_boot_now", {31'd0, boot_now}, 32'd0);
    check_val("rst_boot_sel", {30'd0, boot_sel}, 32'd0);
    wb_rd(3'd0, rd);
    check_val("ctrl_after_rst", rd, 32'h0000_0000);

    // cyc held for two cycles: ack pulses, drops, pulses again; rdata zero in between
    @(negedge clk);
    wb_addr = 3'd2; wb_we = 1'b0; wb_cyc = 1'b1;
    @(negedge clk);
    check_val("hold_ack1", {31'd0, wb_ack}, 32'd1);
    @(negedge clk);
    check_val("hold_ack_gap", {31'd0, wb_ack}, 32'd0);
    check_val("hold_rdata_gap", wb_rdata, 32'd0);
    @(negedge clk);
    check_val("hold_ack2", {31'd0, wb_ack}, 32'd1);
    wb_cyc = 1'b0;

    wb_rd(3'd4, rd);
    check_val("upt_abs", rd, last_edge - 1);
    repeat (10) @(negedge clk);
    wb_rd(3'd4, rd2);
    check_val("upt_diff", rd2 - rd, 32'd12);
    wb_wr(3'd4, 32'hFFFF_FFFF);
    wb_rd(3'd4, rd);
    check_val("upt_clear", rd, 32'd1);

    // ---- 2: delayed boot with DLY=100 ----
    wb_wr(3'd1, 32'd100);
    wb_wr(3'd0, 32'h0000_5A02);
    a = last_edge;
    wb_rd(3'd0, rd);
    check_val("ctrl_delay", rd, 32'h0000_0012);
    wait_boot(300, e);
    check_val("boot_edge_dly100", e, a + 101);
    check_val("boot_sel_2", {30'd0, boot_sel}, 32'd2);
    wb_wr(3'd0, 32'h0000_5A01);
    wb_wr(3'd0, 32'h0000_A504);
    check_val("boot_sel_sticky", {30'd0, boot_sel}, 32'd2);
    check_val("boot_now_sticky", {31'd0, boot_now}, 32'd1);
    wb_rd(3'd0, rd);
    check_val("ctrl_boot", rd, 32'h0000_0022);

    // ---- 3: abort during delay ----
    do_reset();
    wb_wr(3'd1, 32'd1000);
    wb_wr(3'd0, 32'h0000_5A01);
    repeat (200) @(negedge clk);
    wb_wr(3'd0, 32'h0000_A504);
    wb_rd(3'd0, rd);
    check_val("ctrl_abort_state", rd & 32'h30, 32'h0);
    count_boot(2000, hits);
    check_val("no_boot_after_abort", hits, 32'd0);

    // ---- 4: bad key, scratch, unmapped, reset during delay ----
    do_reset();
    wb_wr(3'd0, 32'h0000_1203);
    wb_rd(3'd0, rd);
    check_val("ctrl_bad_key", rd, 32'h0000_0000);
    wb_wr(3'd2, 32'hDEAD_BEEF);
    wb_wr(3'd3, 32'h1234_5678);
    wb_wr(3'd1, 32'hFFFF_1234);
    wb_wr(3'd6, 32'hFFFF_FFFF);
    wb_rd(3'd2, rd);
    check_val("scr0", rd, 32'hDEAD_BEEF);
    wb_rd(3'd3, rd);
    check_val("scr1", rd, 32'h1234_5678);
    wb_rd(3'd1, rd);
    check_val("dly_trunc", rd, 32'h0000_1234);
    wb_rd(3'd6, rd);
    check_val("addr6", rd, 32'h0);
    wb_rd(3'd7, rd);
    check_val("addr7", rd, 32'h0);
    wb_wr(3'd1, 32'd50);
    wb_wr(3'd0, 32'h0000_5A02);
    repeat (10) @(negedge clk);
    do_reset();
    wb_rd(3'd0, rd);
    check_val("rst_dly_ctrl", rd, 32'h0);
    wb_rd(3'd1, rd);
    check_val("rst_dly_dly", rd, 32'h0);
    wb_rd(3'd2, rd);
    check_val("rst_dly_scr0", rd, 32'h0);
    wb_rd(3'd3, rd);
    check_val("rst_dly_scr1", rd, 32'h0);
    count_boot(100, hits);
    check_val("rst_dly_no_boot", hits, 32'd0);

    // ---- DLY rewrite, second start and wrong-key abort during delay are ignored ----
    do_reset();
    wb_wr(3'd1, 32'd20);
    wb_wr(3'd0, 32'h0000_5A01);
    a = last_edge;
    wb_wr(3'd1, 32'd5000);
    wb_wr(3'd0, 32'h0000_5A03);
    wb_wr(3'd0, 32'h0000_1204);
    wait_boot(100, e);
    check_val("boot_edge_dly_rewrite", e, a + 21);
    check_val("boot_sel_first", {30'd0, boot_sel}, 32'd1);
    wb_rd(3'd1, rd);
    check_val("dly_rewritten", rd, 32'd5000);

    // ---- 5: DLY=0 ----
    do_reset();
    wb_wr(3'd1, 32'd0);
    wb_wr(3'd0, 32'h0000_5A03);
    check_val("dly0_before", {31'd0, boot_now}, 32'd0);
    @(negedge clk);
    check_val("dly0_after", {31'd0, boot_now}, 32'd1);
    wb_wr(3'd0, 32'h0000_5A01);
    check_val("dly0_sel", {30'd0, boot_sel}, 32'd3);

    // ---- 6: watchdog ----
    do_reset();
`ifdef SYSCTL_WATCHDOG_EN
    wb_wr(3'd1, 32'd1000);
    wb_wr(3'd0, 32'h0000_5A03);
    wb_wr(3'd5, 32'd50);
    w = last_edge;
    wb_rd(3'd5, rd);
    check_val("wdt_cnt", rd, 32'd49);
    repeat (30) @(negedge clk);
    wb_wr(3'd5, 32'd50);
    f = last_edge;
    check_val("wdt_fed_no_boot", {31'd0, boot_now}, 32'd0);
    wait_boot(120, e);
    check_val("wdt_boot_edge", e, f + 51);
    check_val("wdt_boot_sel", {30'd0, boot_sel}, 32'd0);
    wb_rd(3'd0, rd);
    check_val("wdt_ctrl", rd, 32'h0000_0060);
    c = w;
`else
    wb_wr(3'd5, 32'd50);
    wb_rd(3'd5, rd);
    check_val("wdt_absent_read", rd, 32'h0);
    count_boot(200, hits);
    check_val("wdt_absent_no_boot", hits, 32'd0);
    wb_rd(3'd0, rd);
    check_val("wdt_absent_ctrl", rd, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
